// File: rtl/alu_sequencer.sv
// Issue controller for the edge-triggered ALU: takes one op per handshake, strobes the ALU,
// captures its result/PSW and writes back to the register file and the PSW register it owns.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int E_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_instr,
  input  logic              req_opt,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  input  logic [REG_AW-1:0] req_dst,
  input  logic              flush,
  input  logic              psw_wr,
  input  logic [DATA_W-1:0] psw_wdata,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [5:0]        alu_instr,
  output logic              alu_opt,
  output logic              alu_e,
  output logic [DATA_W-1:0] alu_psw,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_psw_o,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] psw_q,
  output logic              busy,
  output logic              err_illegal
);
  localparam logic [5:0] LastLegal = 6'h1B;
  localparam logic [3:0] StrobeLen = 4'(E_HIGH);

  typedef enum logic [1:0] {IDLE, STROBE, SETTLE, WB} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, legal, noWb;
  logic [DATA_W-1:0] op1_q, op2_q, res_q, pswHold_q, wbData_q;
  logic [5:0]        instr_q;
  logic              opt_q;
  logic [REG_AW-1:0] dst_q, wbDst_q;
  logic              ready_q, ready_d, busy_q, busy_d;
  logic              aluE_q, aluE_d, wbEn_q, wbEn_d, err_q, err_d;

  assign accept = req_valid & ready_q & ~flush;
  assign legal  = (req_instr <= LastLegal);
  assign noWb   = instr_q inside {6'h0A, 6'h0B, 6'h12, 6'h13};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && legal) begin
          state_d = STROBE;
          cnt_d   = StrobeLen;
        end
      end
      STROBE: begin
        if (cnt_q <= 4'd1) state_d = SETTLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SETTLE:  state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Outputs lag the state by one cycle so operands are stable a full cycle before the E edge.
  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    aluE_d  = (state_q == STROBE) & ~flush;
    wbEn_d  = (state_q == WB) & ~flush & ~noWb;
    err_d   = accept & ~legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      aluE_q    <= 1'b0;
      wbEn_q    <= 1'b0;
      err_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      instr_q   <= '0;
      opt_q     <= 1'b0;
      dst_q     <= '0;
      res_q     <= '0;
      pswHold_q <= '0;
      wbData_q  <= '0;
      wbDst_q   <= '0;
      psw_q     <= '0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
      aluE_q  <= aluE_d;
      wbEn_q  <= wbEn_d;
      err_q   <= err_d;
      if (accept && legal) begin
        op1_q   <= req_op1;
        op2_q   <= req_op2;
        instr_q <= req_instr;
        opt_q   <= req_opt;
        dst_q   <= req_dst;
      end
      if (state_q == SETTLE) begin
        res_q     <= alu_result;
        pswHold_q <= alu_psw_o;
      end
      if (state_q == WB && !flush) begin
        wbData_q <= res_q;
        wbDst_q  <= dst_q;
      end
      // An external PSW load overrides the ALU flags landing in the same cycle.
      if (psw_wr)                       psw_q <= psw_wdata;
      else if (state_q == WB && !flush) psw_q <= pswHold_q;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign alu_e       = aluE_q;
  assign wb_en       = wbEn_q;
  assign err_illegal = err_q;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_instr   = instr_q;
  assign alu_opt     = opt_q;
  assign alu_psw     = psw_q;
  assign wb_dst      = wbDst_q;
  assign wb_data     = wbData_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (E_HIGH 1 and 3) share stimulus; each is compared every
// cycle against a timing/value reference model built from the operation rules.
module tb_alu_sequencer;
  localparam int EH0 = 1;
  localparam int EH1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqOpt, flush, pswWr;
  logic [5:0]  reqInstr;
  logic [15:0] reqOp1, reqOp2, pswWdata;
  logic [2:0]  reqDst;

  logic        reqReady[2], aluOpt[2], aluE[2], wbEn[2], busy[2], errIll[2];
  logic [5:0]  aluInstr[2];
  logic [15:0] aluOp1[2], aluOp2[2], aluPsw[2], aluResult[2], aluPswO[2], wbData[2], pswQ[2];
  logic [2:0]  wbDst[2];

  int total = 0;
  int bad = 0;
  int edgeCnt = 0;

  // Reference model state, one slot per instance.
  bit          mActive[2], mOpt[2], mReady[2], mWb[2], mErr[2];
  int          mAcc[2];
  logic [5:0]  mInstr[2];
  logic [15:0] mA[2], mB[2], mPsw[2], mRes[2], mResPsw[2], mWbData[2];
  logic [2:0]  mDst[2], mWbDst[2];

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(16), .REG_AW(3), .E_HIGH(EH0)) dutFast (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady[0]),
    .req_instr(reqInstr), .req_opt(reqOpt), .req_op1(reqOp1), .req_op2(reqOp2),
    .req_dst(reqDst), .flush(flush), .psw_wr(pswWr), .psw_wdata(pswWdata),
    .alu_op1(aluOp1[0]), .alu_op2(aluOp2[0]), .alu_instr(aluInstr[0]), .alu_opt(aluOpt[0]),
    .alu_e(aluE[0]), .alu_psw(aluPsw[0]), .alu_result(aluResult[0]), .alu_psw_o(aluPswO[0]),
    .wb_en(wbEn[0]), .wb_dst(wbDst[0]), .wb_data(wbData[0]), .psw_q(pswQ[0]),
    .busy(busy[0]), .err_illegal(errIll[0])
  );

  alu_sequencer #(.DATA_W(16), .REG_AW(3), .E_HIGH(EH1)) dutSlow (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady[1]),
    .req_instr(reqInstr), .req_opt(reqOpt), .req_op1(reqOp1), .req_op2(reqOp2),
    .req_dst(reqDst), .flush(flush), .psw_wr(pswWr), .psw_wdata(pswWdata),
    .alu_op1(aluOp1[1]), .alu_op2(aluOp2[1]), .alu_instr(aluInstr[1]), .alu_opt(aluOpt[1]),
    .alu_e(aluE[1]), .alu_psw(aluPsw[1]), .alu_result(aluResult[1]), .alu_psw_o(aluPswO[1]),
    .wb_en(wbEn[1]), .wb_dst(wbDst[1]), .wb_data(wbData[1]), .psw_q(pswQ[1]),
    .busy(busy[1]), .err_illegal(errIll[1])
  );

  // Toy ALU: add, cmp (subtract), everything else a mix; flags Z=bit1, C=bit0 when opt is set.
  function automatic logic [31:0] aluFn(input logic [5:0] ins, input logic opt,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] p);
    logic [16:0] r;
    case (ins)
      6'h00:   r = {1'b0, a} + {1'b0, b};
      6'h0A:   r = {1'b0, a} - {1'b0, b};
      default: r = {1'b0, a ^ b ^ {10'b0, ins}};
    endcase
    return {r[15:0], opt ? {p[15:2], (r[15:0] == 16'h0), r[16]} : p};
  endfunction

  always @(posedge aluE[0]) begin
    #1;
    {aluResult[0], aluPswO[0]} = aluFn(aluInstr[0], aluOpt[0], aluOp1[0], aluOp2[0], aluPsw[0]);
  end

  always @(posedge aluE[1]) begin
    #1;
    {aluResult[1], aluPswO[1]} = aluFn(aluInstr[1], aluOpt[1], aluOp1[1], aluOp2[1], aluPsw[1]);
  end

  function automatic int ehOf(input int k);
    return (k == 0) ? EH0 : EH1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset(input int k);
    mActive[k] = 0;
    mReady[k]  = 0;
    mWb[k]     = 0;
    mErr[k]    = 0;
    mPsw[k]    = 16'h0;
  endtask

  // Advance the model of instance k across one rising edge using the inputs held over that edge.
  task automatic modelEdge(input int k);
    int rel;
    bit wasReady, pswLoad;
    wasReady = mReady[k];
    pswLoad  = 0;
    mWb[k]   = 0;
    mErr[k]  = 0;
    if (mActive[k]) begin
      rel = edgeCnt - mAcc[k];
      if (flush) mActive[k] = 0;
      else if (rel == ehOf(k) + 2) begin
        mActive[k] = 0;
        pswLoad    = 1;
        if (!(mInstr[k] inside {6'h0A, 6'h0B, 6'h12, 6'h13})) begin
          mWb[k]     = 1;
          mWbData[k] = mRes[k];
          mWbDst[k]  = mDst[k];
        end
      end
    end else if (wasReady && reqValid && !flush) begin
      if (reqInstr <= 6'h1B) begin
        mActive[k] = 1;
        mAcc[k]    = edgeCnt;
        mInstr[k]  = reqInstr;
        mOpt[k]    = reqOpt;
        mA[k]      = reqOp1;
        mB[k]      = reqOp2;
        mDst[k]    = reqDst;
      end else mErr[k] = 1;
    end
    if (pswWr)        mPsw[k] = pswWdata;
    else if (pswLoad) mPsw[k] = mResPsw[k];
    if (mActive[k] && (edgeCnt - mAcc[k] == 1))
      {mRes[k], mResPsw[k]} = aluFn(mInstr[k], mOpt[k], mA[k], mB[k], mPsw[k]);
    mReady[k] = !mActive[k];
  endtask

  task automatic checkOutput(input int k);
    int rel;
    bit eAluE;
    rel   = edgeCnt - mAcc[k];
    eAluE = mActive[k] && rel >= 1 && rel <= ehOf(k);
    chk($sformatf("req_ready[%0d]@%0d", k, edgeCnt), 32'(reqReady[k]), 32'(mReady[k]));
    chk($sformatf("busy[%0d]@%0d", k, edgeCnt), 32'(busy[k]), 32'(mActive[k]));
    chk($sformatf("alu_e[%0d]@%0d", k, edgeCnt), 32'(aluE[k]), 32'(eAluE));
    chk($sformatf("wb_en[%0d]@%0d", k, edgeCnt), 32'(wbEn[k]), 32'(mWb[k]));
    chk($sformatf("err_illegal[%0d]@%0d", k, edgeCnt), 32'(errIll[k]), 32'(mErr[k]));
    chk($sformatf("psw_q[%0d]@%0d", k, edgeCnt), 32'(pswQ[k]), 32'(mPsw[k]));
    if (mActive[k]) begin
      chk($sformatf("alu_op1[%0d]@%0d", k, edgeCnt), 32'(aluOp1[k]), 32'(mA[k]));
      chk($sformatf("alu_op2[%0d]@%0d", k, edgeCnt), 32'(aluOp2[k]), 32'(mB[k]));
      chk($sformatf("alu_instr[%0d]@%0d", k, edgeCnt), 32'(aluInstr[k]), 32'(mInstr[k]));
      chk($sformatf("alu_opt[%0d]@%0d", k, edgeCnt), 32'(aluOpt[k]), 32'(mOpt[k]));
    end
    if (mWb[k]) begin
      chk($sformatf("wb_data[%0d]@%0d", k, edgeCnt), 32'(wbData[k]), 32'(mWbData[k]));
      chk($sformatf("wb_dst[%0d]@%0d", k, edgeCnt), 32'(wbDst[k]), 32'(mWbDst[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edgeCnt++;
    for (int k = 0; k < 2; k++) begin
      if (rst) modelReset(k);
      else     modelEdge(k);
    end
    #1;
    for (int k = 0; k < 2; k++) checkOutput(k);
  endtask

  // Present one request for a single edge, then withdraw it.
  task automatic applyStimulus(input logic [5:0] ins, input logic opt, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] dst);
    reqValid = 1'b1;
    reqInstr = ins;
    reqOpt   = opt;
    reqOp1   = a;
    reqOp2   = b;
    reqDst   = dst;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic settle();
    repeat (EH1 + 3) tick();
  endtask

  initial begin
    int wbEdge[2][2];
    int wbSeen[2];
    rst      = 1'b1;
    reqValid = 1'b0;
    reqInstr = 6'h0;
    reqOpt   = 1'b0;
    reqOp1   = 16'h0;
    reqOp2   = 16'h0;
    reqDst   = 3'h0;
    flush    = 1'b0;
    pswWr    = 1'b0;
    pswWdata = 16'h0;
    for (int k = 0; k < 2; k++) modelReset(k);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 32'(reqReady[k]), 32'h0);
      chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'h0);
      chk($sformatf("rst_alu_e[%0d]", k), 32'(aluE[k]), 32'h0);
      chk($sformatf("rst_wb_en[%0d]", k), 32'(wbEn[k]), 32'h0);
      chk($sformatf("rst_psw[%0d]", k), 32'(pswQ[k]), 32'h0);
      chk($sformatf("rst_err[%0d]", k), 32'(errIll[k]), 32'h0);
    end
    rst = 1'b0;
    tick();

    $display("[TB] add, E_HIGH=1 writeback three cycles after transfer");
    applyStimulus(6'h00, 1'b0, 16'h1234, 16'h0001, 3'd3);
    repeat (3) tick();
    chk("add_wb_en", 32'(wbEn[0]), 32'h1);
    chk("add_wb_data", 32'(wbData[0]), 32'h1235);
    chk("add_wb_dst", 32'(wbDst[0]), 32'h3);
    settle();

    $display("[TB] cmp sets Z without writeback");
    applyStimulus(6'h0A, 1'b1, 16'h0005, 16'h0005, 3'd1);
    settle();
    for (int k = 0; k < 2; k++) chk($sformatf("cmp_z[%0d]", k), 32'(pswQ[k][1]), 32'h1);

    $display("[TB] illegal opcode");
    applyStimulus(6'h1F, 1'b1, 16'h1111, 16'h2222, 3'd2);
    chk("illegal_err", 32'(errIll[0]), 32'h1);
    settle();

    $display("[TB] psw_wr collides with writeback");
    applyStimulus(6'h00, 1'b1, 16'hFFFF, 16'h0001, 3'd5);
    repeat (2) tick();
    pswWr    = 1'b1;
    pswWdata = 16'h0010;
    tick();
    pswWr = 1'b0;
    chk("pswwr_wins", 32'(pswQ[0]), 32'h0010);
    settle();

    $display("[TB] flush during strobe");
    applyStimulus(6'h00, 1'b0, 16'h0003, 16'h0004, 3'd7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_alu_e", 32'(aluE[1]), 32'h0);
    applyStimulus(6'h00, 1'b0, 16'h0010, 16'h0020, 3'd4);
    settle();

    $display("[TB] back-to-back held request");
    wbSeen = '{0, 0};
    reqValid = 1'b1;
    reqInstr = 6'h00;
    reqOpt   = 1'b0;
    reqOp1   = 16'h0100;
    reqOp2   = 16'h0023;
    reqDst   = 3'd6;
    repeat (16) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (wbEn[k] && wbSeen[k] < 2) begin
          wbEdge[k][wbSeen[k]] = edgeCnt;
          wbSeen[k]++;
        end
    end
    reqValid = 1'b0;
    chk("b2b_spacing_e1", (wbSeen[0] == 2) ? 32'(wbEdge[0][1] - wbEdge[0][0]) : 32'hFFFF_FFFF, 32'd4);
    chk("b2b_spacing_e3", (wbSeen[1] == 2) ? 32'(wbEdge[1][1] - wbEdge[1][0]) : 32'hFFFF_FFFF, 32'd6);
    settle();

    $display("[TB] reset mid-operation");
    applyStimulus(6'h00, 1'b0, 16'h0042, 16'h0001, 3'd1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_alu_e", 32'(aluE[1]), 32'h0);
    chk("async_rst_busy", 32'(busy[1]), 32'h0);
    chk("async_rst_ready", 32'(reqReady[1]), 32'h0);
    for (int k = 0; k < 2; k++) modelReset(k);
    #1 rst = 1'b0;
    tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      reqValid = 1'($urandom_range(1, 0));
      reqInstr = 6'($urandom_range(31, 0));
      reqOpt   = 1'($urandom_range(1, 0));
      reqOp1   = 16'($urandom);
      reqOp2   = ($urandom_range(3, 0) == 0) ? reqOp1 : 16'($urandom);
      reqDst   = 3'($urandom_range(7, 0));
      flush    = ($urandom_range(19, 0) == 0);
      pswWr    = ($urandom_range(14, 0) == 0);
      pswWdata = 16'($urandom);
      tick();
    end
    reqValid = 1'b0;
    flush    = 1'b0;
    pswWr    = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
